flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
Parametrised successor to the controller's combinational flag multiplexer. Holds a bank of sticky condition flags and evaluates branch/wait conditions against them through a valid/ready request and response handshake. A condition can optionally be inverted, can block until it becomes true (with timeout), and can consume its flag when taken. It sits between the PIM datapath flag sources and the instruction sequencer's branch/wait logic.

Parameters:
SEL_W, 3, width of condition select; NUM_FLAGS = 2**SEL_W - 1; select value all-ones means "always true"
TMO_W, 16, width of wait-timeout counter

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  synchronous active-low reset
flag_set  in  NUM_FLAGS  per-flag set strobe
flag_clr  in  NUM_FLAGS  per-flag clear strobe
flag_q  out  NUM_FLAGS  current sticky flag register
req_valid  in  1  condition request valid
req_ready  out  1  unit can accept a request
req_sel  in  SEL_W  flag index; all-ones = unconditional
req_invert  in  1  test for flag == 0 instead of 1
req_wait  in  1  block until the condition is true or the timeout expires
req_consume  in  1  clear the selected flag when the condition is taken
req_timeout  in  TMO_W  wait budget in cycles; 0 = wait forever
resp_valid  out  1  response valid
resp_ready  in  1  sequencer accepts the response
resp_taken  out  1  condition evaluated true
resp_timeout  out  1  wait ended by timeout

Behaviour:
- Reset (rst_n=0 at a clk edge): flag_q=0, FSM=IDLE, req_ready=1, resp_valid=0, resp_taken=0, resp_timeout=0, counter=0, captured request fields=0. Reset mid-wait or mid-response abandons the request; no flag is consumed.
- Flag register update, per bit, every cycle: next = (q & ~flag_clr & ~consume_mask) | flag_set. Set beats both clears in the same cycle.
- cond = 1 if sel is all-ones; otherwise cond = flag_q[sel] XOR invert. Evaluation uses the registered flag_q only, so a set strobe is first visible one cycle later.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture sel, invert, consume and timeout.
    - If cond is true, or req_wait=0: go to RESP with taken=cond and timeout=0.
    - Otherwise: go to WAIT and load counter=req_timeout.
  - WAIT: req_ready=0. Each cycle:
    - If cond is true: go to RESP with taken=1.
    - Else if counter==1: go to RESP with taken=0 and timeout=1.
    - Else: decrement the counter, unless it is 0 (infinite wait), in which case it holds.
  - RESP: resp_valid=1 and req_ready=0. resp_taken and resp_timeout stay stable until resp_ready=1, then return to IDLE. There is no back-to-back accept in the same cycle as the response handshake.
- Latency:
  - Non-waiting request: resp_valid rises 1 cycle after acceptance.
  - Waiting request with timeout T>0: the flag is checked at acceptance plus T WAIT cycles; worst-case resp_valid is T+1 cycles after acceptance.
- Consume: applied in the cycle of the transition into RESP, and only when taken=1, consume=1, sel is not all-ones, and invert=0. The flag reads 0 from the next cycle unless flag_set is active in that same cycle.
- resp_taken and resp_timeout are never both 1.

Test Plan:
1. Reset, then flag_set=7'b0000100 for 1 cycle; next cycle request sel=2, wait=0 -> flag_q=7'b0000100; resp_valid 1 cycle after accept, taken=1, timeout=0.
2. Request sel=7 (all-ones) with flag_q=0, invert=1 -> taken=1. Request sel=3, invert=1 with flag_q[3]=0 -> taken=1. Request sel=3, invert=0 -> taken=0.
3. Request sel=5, wait=1, timeout=4, flag never set -> resp at accept+5, taken=0, timeout=1. Same request with flag_set[5] pulsed 2 cycles after accept -> resp at accept+4, taken=1.
4. Request sel=1, consume=1, flag_q[1]=1 -> taken=1 and flag_q[1]=0 next cycle. Repeat with flag_set[1] held in the consume cycle -> flag_q[1] stays 1. Set and clear strobed together on flag 0 -> flag_q[0]=1.
5. Hold resp_ready=0 for 6 cycles in RESP -> resp_valid and resp_taken stable, req_ready=0, a new req_valid is ignored; resp_ready=1 -> IDLE and req_ready=1 the next cycle.
6. Request with wait=1, timeout=0 and flag clear for 100 cycles, then rst_n=0 -> FSM is in IDLE after the edge, all outputs 0 except req_ready=1, flag_q=0.

Source files
------------

// File: rtl/flag_cond_unit.sv
// flag_cond_unit
//   Sticky condition-flag bank with a branch/wait condition evaluator that
//   talks to the sequencer over a request/response valid/ready handshake.
//   Flags are set and cleared by datapath strobes. A request selects a flag,
//   or all-ones for "always true". The request can invert the test, block
//   until the condition holds (with an optional timeout), and consume the
//   flag when the condition is taken.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   flag_set / flag_clr   per-flag strobes (set wins over clear)
//   flag_q                registered flag bank
//   req_*                 condition request (valid/ready)
//   resp_*                response (valid/ready); taken / timeout outcome
module flag_cond_unit #(
  parameter  int SEL_W     = 3,
  parameter  int TMO_W     = 16,
  localparam int NUM_FLAGS = 2**SEL_W - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FLAGS-1:0] flag_set,
  input  logic [NUM_FLAGS-1:0] flag_clr,
  output logic [NUM_FLAGS-1:0] flag_q,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEL_W-1:0]     req_sel,
  input  logic                 req_invert,
  input  logic                 req_wait,
  input  logic                 req_consume,
  input  logic [TMO_W-1:0]     req_timeout,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_taken,
  output logic                 resp_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [TMO_W-1:0]   cnt;
  logic [SEL_W-1:0]   cap_sel;
  logic               cap_invert;
  logic               cap_consume;

  // In IDLE the live request is evaluated; afterwards the captured copy.
  logic [SEL_W-1:0]   ev_sel;
  logic               ev_inv, ev_cons;
  logic               sel_all;
  logic [NUM_FLAGS:0] flag_ext;
  logic               cond;
  logic               go_take;
  logic               consume_en;
  logic [NUM_FLAGS-1:0] consume_mask;

  always_comb begin
    ev_sel  = cap_sel;
    ev_inv  = cap_invert;
    ev_cons = cap_consume;
    if (state == S_IDLE) begin
      ev_sel  = req_sel;
      ev_inv  = req_invert;
      ev_cons = req_consume;
    end
  end

  // Top entry of the extended vector is the hard "always true" slot, so the
  // all-ones select never indexes past the real flags.
  assign sel_all  = &ev_sel;
  assign flag_ext = {1'b1, flag_q};
  assign cond     = flag_ext[ev_sel] ^ (ev_inv & ~sel_all);

  // Taken transition into RESP happens on this edge.
  assign go_take    = cond & ((state == S_IDLE && req_valid) || state == S_WAIT);
  assign consume_en = go_take & ev_cons & ~ev_inv & ~sel_all;

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_mask
    assign consume_mask[i] = consume_en && (ev_sel == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flag_q <= '0;
    else        flag_q <= (flag_q & ~flag_clr & ~consume_mask) | flag_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_taken   <= 1'b0;
      resp_timeout <= 1'b0;
      cnt          <= '0;
      cap_sel      <= '0;
      cap_invert   <= 1'b0;
      cap_consume  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_sel     <= req_sel;
            cap_invert  <= req_invert;
            cap_consume <= req_consume;
            req_ready   <= 1'b0;
            if (cond || !req_wait) begin
              state        <= S_RESP;
              resp_valid   <= 1'b1;
              resp_taken   <= cond;
              resp_timeout <= 1'b0;
            end else begin
              state <= S_WAIT;
              cnt   <= req_timeout;
            end
          end
        end
        S_WAIT: begin
          if (cond) begin
            state        <= S_RESP;
            resp_valid   <= 1'b1;
            resp_taken   <= 1'b1;
            resp_timeout <= 1'b0;
          end else if (cnt == TMO_W'(1)) begin
            state        <= S_RESP;
            resp_valid   <= 1'b1;
            resp_taken   <= 1'b0;
            resp_timeout <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - TMO_W'(1);   // zero budget holds: wait forever
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_taken   <= 1'b0;
            resp_timeout <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit. Each request's outcome and
// response latency is predicted analytically from the flag state at
// acceptance and the cycle at which the bench flips the selected flag.
module tb_flag_cond_unit;
  localparam int SEL_W = 3;
  localparam int TMO_W = 16;
  localparam int NF    = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NF-1:0]     flag_set, flag_clr, flag_q;
  logic              req_valid, req_ready;
  logic [SEL_W-1:0]  req_sel;
  logic              req_invert, req_wait, req_consume;
  logic [TMO_W-1:0]  req_timeout;
  logic              resp_valid, resp_ready, resp_taken, resp_timeout;

  flag_cond_unit #(.SEL_W(SEL_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_set(flag_set), .flag_clr(flag_clr), .flag_q(flag_q),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_invert(req_invert), .req_wait(req_wait), .req_consume(req_consume),
    .req_timeout(req_timeout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [NF-1:0] mflags;   // reference flag bank
  logic [NF-1:0] mmask;    // flag the model expects to be consumed this edge

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; the model sees the same strobes the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) mflags = '0;
    else        mflags = (mflags & ~flag_clr & ~mmask) | flag_set;
    #1;
  endtask

  // k: cycle after acceptance at which the selected flag is flipped toward
  // "true" (-1 = never). hold: cycles resp_ready stays low in RESP.
  task automatic run_req(input int sel, input bit inv, input bit wt, input bit cons,
                         input int tmo, input int k, input int hold, input bit setcons,
                         input bit noise);
    logic [NF-1:0] selbit, ns, nc;
    bit cond0, taken, tmo_exp, cons_exp;
    int lat;
    selbit = (sel == 7) ? '0 : NF'(1 << sel);
    cond0  = (sel == 7) ? 1'b1 : (mflags[sel] ^ inv);
    if (!wt || cond0) begin
      lat = 1; taken = cond0; tmo_exp = 0;
    end else if (k >= 1 && (tmo == 0 || k <= tmo - 1)) begin
      lat = k + 2; taken = 1; tmo_exp = 0;
    end else begin
      lat = tmo + 1; taken = 0; tmo_exp = 1;
    end
    cons_exp = taken && cons && sel != 7 && !inv;
    check("idle_ready", req_ready, 1);
    req_valid = 1; req_sel = SEL_W'(sel); req_invert = inv; req_wait = wt;
    req_consume = cons; req_timeout = TMO_W'(tmo);
    for (int c = 0; c < lat; c++) begin
      ns = noise ? (NF'($urandom) & NF'($urandom) & ~selbit) : '0;
      nc = noise ? (NF'($urandom) & NF'($urandom) & ~selbit) : '0;
      if (c == k) begin
        if (inv) nc |= selbit; else ns |= selbit;
      end
      mmask = (c == lat - 1 && cons_exp) ? selbit : '0;
      if (c == lat - 1 && cons_exp && setcons) ns |= selbit;
      flag_set = ns; flag_clr = nc;
      if (c == 1) req_valid = 0;
      tick();
      req_valid = 0;
      check("flag_q", flag_q, mflags);
      check("resp_valid_lat", resp_valid, (c == lat - 1));
      if (c < lat - 1) check("busy_ready", req_ready, 0);
    end
    flag_set = '0; flag_clr = '0; mmask = '0;
    check("resp_taken", resp_taken, taken);
    check("resp_timeout", resp_timeout, tmo_exp);
    check("taken_xor_tmo", resp_taken & resp_timeout, 0);
    // Held response: a fresh "always true" request must be ignored.
    for (int h = 0; h < hold; h++) begin
      req_valid = 1; req_sel = '1; req_wait = 0;
      tick();
      check("hold_valid", resp_valid, 1);
      check("hold_taken", resp_taken, taken);
      check("hold_tmo", resp_timeout, tmo_exp);
      check("hold_ready", req_ready, 0);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0; req_valid = 0;
    check("done_valid", resp_valid, 0);
    check("done_ready", req_ready, 1);
    check("done_flags", flag_q, mflags);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, tmo, k;
    bit inv, wt, cond0;
    rst_n = 0; flag_set = '0; flag_clr = '0; req_valid = 0; req_sel = '0;
    req_invert = 0; req_wait = 0; req_consume = 0; req_timeout = '0;
    resp_ready = 0; mflags = '0; mmask = '0;
    tick(); tick();
    check("rst_ready", req_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_taken", resp_taken, 0);
    check("rst_tmo", resp_timeout, 0);
    check("rst_flags", flag_q, 0);
    rst_n = 1; tick();

    // 1: set flag 2, then plain test
    flag_set = 7'b0000100; tick(); flag_set = '0;
    check("set_vis", flag_q, 7'b0000100);
    run_req(2, 0, 0, 0, 0, -1, 0, 0, 0);
    // 2: unconditional / inverted selects on a clear bank
    flag_clr = '1; tick(); flag_clr = '0;
    run_req(7, 1, 0, 0, 0, -1, 0, 0, 0);
    run_req(3, 1, 0, 0, 0, -1, 0, 0, 0);
    run_req(3, 0, 0, 0, 0, -1, 0, 0, 0);
    // 3: timeout vs. flag arriving mid-wait
    run_req(5, 0, 1, 0, 4, -1, 0, 0, 0);
    run_req(5, 0, 1, 0, 4, 2, 0, 0, 0);
    run_req(4, 0, 1, 0, 4, 3, 0, 0, 0);   // last-chance arrival
    run_req(4, 1, 1, 0, 1, -1, 0, 0, 0);  // flag 4 set, inverted, budget 1
    // 4: consume, consume racing set, set racing clear
    flag_set = 7'b0000010; tick(); flag_set = '0;
    run_req(1, 0, 0, 1, 0, -1, 0, 0, 0);
    check("consumed", flag_q[1], 0);
    flag_set = 7'b0000010; tick(); flag_set = '0;
    run_req(1, 0, 0, 1, 0, -1, 0, 1, 0);
    check("consume_vs_set", flag_q[1], 1);
    run_req(6, 0, 1, 1, 0, 3, 0, 0, 0);   // infinite wait, consume after wait
    flag_set = 7'b0000001; flag_clr = 7'b0000001; tick();
    flag_set = '0; flag_clr = '0;
    check("set_beats_clr", flag_q[0], 1);
    // 5: stalled response
    run_req(0, 0, 0, 0, 0, -1, 6, 0, 0);

    // Randomized requests with background flag traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      inv = 1'($urandom); wt = 1'($urandom);
      tmo = $urandom_range(0, 6);
      k   = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 8);
      cond0 = (sel == 7) ? 1'b1 : (mflags[sel] ^ inv);
      if (wt && !cond0 && tmo == 0 && k < 0) k = $urandom_range(1, 8);
      run_req(sel, inv, wt, 1'($urandom), tmo, k, $urandom_range(0, 3),
              1'($urandom), 1);
    end

    // 6: reset abandons an endless wait
    flag_clr = 7'b0010000; tick(); flag_clr = '0;
    req_valid = 1; req_sel = 3'd4; req_invert = 0; req_wait = 1;
    req_consume = 1; req_timeout = '0;
    tick(); req_valid = 0;
    flag_set = 7'b0001011; tick(); flag_set = '0;
    for (int c = 0; c < 100; c++) tick();
    check("wait_forever_valid", resp_valid, 0);
    check("wait_forever_ready", req_ready, 0);
    check("wait_flags", flag_q, mflags);
    rst_n = 0; tick();
    check("rst2_ready", req_ready, 1);
    check("rst2_valid", resp_valid, 0);
    check("rst2_taken", resp_taken, 0);
    check("rst2_tmo", resp_timeout, 0);
    check("rst2_flags", flag_q, 0);
    rst_n = 1; tick();
    run_req(7, 0, 0, 0, 0, -1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
